deserializer: RTL and testbench

Receive-side partner of the serializer. Samples a one-bit MSB-first stream qualified by a valid strobe and reassembles words of 1..16 bits. Presents each word left-aligned in a 16-bit register with a one-cycle valid pulse. Sits directly downstream of the serializer: its `ser_data_o` and `ser_data_val_o` feed this block's `ser_data_i` and `ser_data_val_i`, and both blocks use the same `data_mod` word-length encoding.

---
 rtl/deser_pkg.sv | 24 ++
 rtl/deser_counter.sv | 45 ++++
 rtl/deserializer.sv | 127 ++++++++++++
 tb/tb_deserializer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared definitions for the deserializer slice.
//   MAX_WIDTH    : widest word the block assembles (16 bits)
//   CNT_W        : width of the bit counter and of the data_mod encoding
//   deser_state_t: receive FSM states
//   clamp_mod    : maps a raw data_mod value onto a legal word length 1..16
package deser_pkg;

    localparam int unsigned MAX_WIDTH = 16;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic {
        IDLE,
        SHIFT
    } deser_state_t;

    // 0 and anything above MAX_WIDTH select a full-width word.
    function automatic logic [CNT_W-1:0] clamp_mod(input logic [CNT_W-1:0] m);
        if (m == '0 || m > CNT_W'(MAX_WIDTH)) begin
            return CNT_W'(MAX_WIDTH);
        end
        return m;
    endfunction

endpackage

// File: rtl/deser_counter.sv
// Up-counter with synchronous clear, enable and terminal-count detect.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : restart from zero (an enable in the same cycle counts 1)
//   en_i         : count this cycle
//   limit_i      : terminal value
//   cnt_o        : current count
//   tc_o         : this cycle's increment reaches limit_i; the counter
//                  wraps to zero on that edge
module deser_counter
    import deser_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = (clr_i ? '0 : cnt_q) + W'(en_i);
    end

    // Compare on the incremented value so the terminal edge is known in
    // the same cycle the last event is sampled.
    assign tc_o  = en_i && (cnt_nxt == limit_i);
    assign cnt_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (tc_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

endmodule

// File: rtl/deserializer.sv
// Reassembles an MSB-first serial stream into left-aligned words of 1..16 bits.
//   TIMEOUT        : idle cycles tolerated inside a word before abort (0 = never)
//   clk_i, rst_i   : clock, synchronous active-high reset
//   ser_data_i     : serial bit, MSB first
//   ser_data_val_i : qualifies ser_data_i; gaps allowed mid-word
//   data_mod_i     : word length, latched at the first bit of each word
//   data_o         : last completed word, left-aligned, unused LSBs zero
//   data_val_o     : one-cycle pulse when data_o updates
//   busy_o         : a word is partially received
//   err_o          : one-cycle pulse when a partial word times out
module deserializer
    import deser_pkg::*;
#(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ser_data_i,
    input  logic                 ser_data_val_i,
    input  logic [CNT_W-1:0]     data_mod_i,
    output logic [MAX_WIDTH-1:0] data_o,
    output logic                 data_val_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TO_EN  = (TIMEOUT != 0);

    deser_state_t         state_q, state_nxt;
    logic                 in_idle;
    logic [CNT_W-1:0]     n_q, n_eff, bit_cnt, cur;
    logic                 done, abort;
    logic                 idle_en, idle_clr;
    logic [IDLE_W-1:0]    idle_cnt_unused;
    logic [MAX_WIDTH-1:0] shreg_q, shreg_nxt, word_nxt;

    assign in_idle = (state_q == IDLE);

    // In IDLE the length comes straight from the port so a 1-bit word can
    // complete on its only sample; afterwards the latched value is used.
    assign n_eff = in_idle ? clamp_mod(data_mod_i) : n_q;

    deser_counter #(.W(CNT_W)) u_bit_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (in_idle),
        .en_i    (ser_data_val_i),
        .limit_i (n_eff),
        .cnt_o   (bit_cnt),
        .tc_o    (done)
    );

    assign idle_clr = in_idle || ser_data_val_i;
    assign idle_en  = TO_EN && !in_idle && !ser_data_val_i;

    deser_counter #(.W(IDLE_W)) u_idle_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (idle_clr),
        .en_i    (idle_en),
        .limit_i (IDLE_W'(TIMEOUT)),
        .cnt_o   (idle_cnt_unused),
        .tc_o    (abort)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE: begin
                if (ser_data_val_i && !done) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (done || abort) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Assembly datapath: each new bit is ORed in below the ones already
    // held, since the register is cleared at the start of every word.
    always_comb begin
        cur       = in_idle ? '0 : bit_cnt;
        shreg_nxt = in_idle ? '0 : shreg_q;
        if (ser_data_val_i) begin
            shreg_nxt = shreg_nxt | ({ser_data_i, {(MAX_WIDTH-1){1'b0}}} >> cur);
        end
        word_nxt = shreg_nxt & ({MAX_WIDTH{1'b1}} << (CNT_W'(MAX_WIDTH) - n_eff));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q    <= '0;
            n_q        <= '0;
            data_o     <= '0;
            data_val_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            shreg_q    <= shreg_nxt;
            data_val_o <= done;
            err_o      <= abort;
            if (in_idle && ser_data_val_i) begin
                n_q <= n_eff;
            end
            if (done) begin
                data_o <= word_nxt;
            end
        end
    end

    assign busy_o = (state_q == SHIFT);

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ser_data_i;
    logic        ser_data_val_i;
    logic [4:0]  data_mod_i;
    logic [15:0] data_o;
    logic        data_val_o;
    logic        busy_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_data = 16'h0000;

    deserializer #(.TIMEOUT(TO)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ser_data_i     (ser_data_i),
        .ser_data_val_i (ser_data_val_i),
        .data_mod_i     (data_mod_i),
        .data_o         (data_o),
        .data_val_o     (data_val_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic busy, input logic dval, input logic err);
        chk({tag, ".busy"}, 16'(busy_o), 16'(busy));
        chk({tag, ".dval"}, 16'(data_val_o), 16'(dval));
        chk({tag, ".err"},  16'(err_o), 16'(err));
        chk({tag, ".data"}, data_o, exp_data);
    endtask

    // Idle cycles between words: nothing may happen.
    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            ser_data_val_i = 1'b0;
            ser_data_i     = 1'($urandom);
            @(posedge clk_i); #1;
            chk_all("idle", 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Send one word of length clamp(mod); mod_later is presented on the port
    // after the first bit. A gap of gap_len idle cycles follows bit gap_pos;
    // a gap of TO or more aborts the word and the rest is not sent.
    task automatic send(input logic [4:0] mod, input logic [4:0] mod_later,
                        input logic [15:0] word, input int gap_pos, input int gap_len);
        int n;
        bit abort_exp;
        n = (mod == 0 || mod > 16) ? 16 : int'(mod);
        abort_exp = (gap_len >= TO) && (gap_pos >= 0) && (gap_pos < n - 1);
        for (int i = 0; i < n; i++) begin
            data_mod_i     = (i == 0) ? mod : mod_later;
            ser_data_val_i = 1'b1;
            ser_data_i     = word[15-i];
            @(posedge clk_i); #1;
            if (i == n - 1) begin
                exp_data = word & ~(16'hFFFF >> n);
                chk_all("last_bit", 1'b0, 1'b1, 1'b0);
            end else begin
                chk_all("mid_bit", 1'b1, 1'b0, 1'b0);
            end
            if (i == gap_pos && gap_len > 0 && i < n - 1) begin
                for (int k = 1; k <= gap_len; k++) begin
                    ser_data_val_i = 1'b0;
                    ser_data_i     = 1'($urandom);
                    @(posedge clk_i); #1;
                    if (abort_exp && k == TO)
                        chk_all("gap_abort", 1'b0, 1'b0, 1'b1);
                    else if (abort_exp && k > TO)
                        chk_all("gap_after", 1'b0, 1'b0, 1'b0);
                    else
                        chk_all("gap_wait", 1'b1, 1'b0, 1'b0);
                end
                if (abort_exp) return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, gp, gl;
        logic [4:0]  m;
        logic [15:0] w;

        rst_i          = 1'b1;
        ser_data_i     = 1'b0;
        ser_data_val_i = 1'b0;
        data_mod_i     = 5'd0;
        repeat (2) @(posedge clk_i);
        #1;
        chk_all("reset", 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        idle(2);

        // Full-width word, continuous valid
        send(5'd16, 5'd16, 16'hA5C3, -1, 0);
        idle(1);

        // Two 4-bit words back to back
        send(5'd4, 5'd4, 16'hB000, -1, 0);
        send(5'd4, 5'd4, 16'h6000, -1, 0);
        idle(2);

        // Length 0 treated as 16, then single-bit word
        send(5'd0, 5'd0, 16'hFFFF, -1, 0);
        idle(1);
        send(5'd1, 5'd1, 16'h8000, -1, 0);
        idle(2);

        // Gap just below the timeout, then exactly at it
        send(5'd8, 5'd8, 16'hD700, 2, TO - 1);
        idle(1);
        send(5'd8, 5'd8, 16'h5A00, 2, TO);
        idle(2);

        // Reset in the middle of a word
        data_mod_i = 5'd8;
        for (int i = 0; i < 5; i++) begin
            ser_data_val_i = 1'b1;
            ser_data_i     = 1'(i & 1);
            @(posedge clk_i); #1;
            chk_all("pre_rst", 1'b1, 1'b0, 1'b0);
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        exp_data = 16'h0000;
        chk_all("mid_rst", 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        send(5'd8, 5'd8, 16'h3C00, -1, 0);
        idle(1);

        // Length change mid-word applies to the next word only
        send(5'd8, 5'd2, 16'h9600, -1, 0);
        send(5'd2, 5'd2, 16'h4000, -1, 0);
        idle(1);

        // Random words, lengths (including out-of-range codes) and gaps
        for (int t = 0; t < 40; t++) begin
            m  = 5'($urandom_range(0, 31));
            n  = (m == 0 || m > 16) ? 16 : int'(m);
            w  = 16'($urandom);
            gp = (n > 1) ? int'($urandom_range(0, n - 2)) : -1;
            gl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TO + 2)) : 0;
            send(m, 5'($urandom_range(0, 31)), w, gp, gl);
            idle(int'($urandom_range(0, 2)));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
